// File: rtl/prince_ti_pkg.sv
// prince_ti_pkg: shared constants and state type for the PRINCE TI share unmasking block.
package prince_ti_pkg;
   localparam int BYTE_W     = 8;
   localparam int SHARES_DEF = 4;
   localparam int BEATS_DEF  = 8;
   localparam int STATE_W    = BYTE_W * BEATS_DEF;
   localparam int CNT_W      = $clog2(BEATS_DEF);
   typedef enum logic [1:0] {COLLECT, COMBINE, OUTPUT} unmask_state_t;
endpackage

// File: rtl/prince_ti_share_buf.sv
// prince_ti_share_buf: one byte-addressed share register, written a byte per accepted beat.
module prince_ti_share_buf import prince_ti_pkg::*; #(
   parameter int BEATS = BEATS_DEF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        we,
   input  logic [$clog2(BEATS)-1:0]    idx,
   input  logic [BYTE_W-1:0]           din,
   input  logic                        zero,
   output logic [BYTE_W*BEATS-1:0]     q
);
   always_ff @(posedge clk) begin
      if (rst || zero) q <= '0;
      else if (we) q[BYTE_W*idx +: BYTE_W] <= din;
   end
endmodule

// File: rtl/prince_ti_share_unmask.sv
// prince_ti_share_unmask: collects byte-serial Boolean shares and recombines them in one registered XOR stage.
// Optional macro PRINCE_UNMASK_ZEROIZE_EN clears share buffers and out_data on the output handshake.
module prince_ti_share_unmask import prince_ti_pkg::*; #(
   parameter int SHARES = SHARES_DEF,
   parameter int BEATS  = BEATS_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [BYTE_W*SHARES-1:0]   in_shares,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [BYTE_W*BEATS-1:0]    out_data,
   output logic                       busy
);
   localparam int W  = BYTE_W * BEATS;
   localparam int CW = $clog2(BEATS);
`ifdef PRINCE_UNMASK_ZEROIZE_EN
   localparam bit ZEROIZE = 1'b1;
`else
   localparam bit ZEROIZE = 1'b0;
`endif
   unmask_state_t state, state_nxt;
   logic [CW-1:0] cnt;
   logic [W-1:0]  bufs [SHARES];
   logic [W-1:0]  comb_x;
   logic          acc, last, hs, zero;
   assign acc  = in_valid && in_ready;
   assign last = acc && (cnt == CW'(BEATS-1));
   assign hs   = out_valid && out_ready;
   assign zero = ZEROIZE && hs;
   for (genvar i = 0; i < SHARES; i++) begin : g_buf
      prince_ti_share_buf #(.BEATS(BEATS)) u_buf (
         .clk  (clk),
         .rst  (rst),
         .we   (acc),
         .idx  (cnt),
         .din  (in_shares[BYTE_W*i +: BYTE_W]),
         .zero (zero),
         .q    (bufs[i])
      );
   end
   // Shares meet only here, and the result is registered before leaving the block.
   always_comb begin
      comb_x = '0;
      for (int s = 0; s < SHARES; s++) comb_x = comb_x ^ bufs[s];
   end
   always_ff @(posedge clk) begin
      if (rst) state <= COLLECT;
      else state <= state_nxt;
   end
   always_comb begin
      state_nxt = (state == COLLECT && last) ? COMBINE :
                  (state == COMBINE)         ? OUTPUT  :
                  (state == OUTPUT && hs)    ? COLLECT : state;
   end
   always_comb begin
      in_ready = !rst && state == COLLECT;
      busy     = !rst && !(state == COLLECT && cnt == '0);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         if (acc) cnt <= last ? '0 : cnt + 1'b1;
         if (state == COMBINE) begin
            out_data  <= comb_x;
            out_valid <= 1'b1;
         end else if (hs) begin
            out_valid <= 1'b0;
            if (ZEROIZE) out_data <= '0;
         end
      end
   end
endmodule
